// File: rtl/line_clear_unit.sv
// Clears full rows from an 8x4 board one row per cycle, dropping upper rows and scoring the clear.
// Latency 8+L cycles from accept to done (L = rows cleared); start is ignored while busy.
module line_clear_unit #(
  parameter int SCORE_W = 16
) (
  input  logic               clka,
  input  logic               restart_n,
  input  logic               start,
  input  logic [31:0]        board_in,
  output logic               busy,
  output logic               done,
  output logic [31:0]        board_out,
  output logic [3:0]         lines,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        work_q, work_d;
  logic [3:0]         r_q, r_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        board_q, board_d;
  logic [3:0]         lines_q, lines_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic [3:0]         row_sel;
  logic [31:0]        low_mask;
  logic [31:0]        shifted;
  logic               row_full;
  logic               scan_exit;
  logic [3:0]         inc;
  logic [SCORE_W:0]   sum;

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      board_q <= '0;
      lines_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      board_q <= board_d;
      lines_q <= lines_d;
      score_q <= score_d;
    end
  end

  // Rows below the pointer stay put; everything from the pointer up drops by one row.
  always_comb begin
    row_sel   = work_q[{r_q[2:0], 2'b00} +: 4];
    low_mask  = (32'h1 << {r_q[2:0], 2'b00}) - 32'h1;
    shifted   = (work_q & low_mask) | ((work_q >> 4) & ~low_mask);
    row_full  = (row_sel == 4'hF);
    scan_exit = (state_q == SCAN) && !row_full && (r_q == 4'd7);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (scan_exit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    case (cnt_q)
      4'd0:    inc = 4'd0;
      4'd1:    inc = 4'd1;
      4'd2:    inc = 4'd3;
      4'd3:    inc = 4'd5;
      default: inc = 4'd8;
    endcase
    sum = {1'b0, score_q} + (SCORE_W+1)'(inc);
  end

  always_comb begin
    work_d  = work_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    board_d = board_q;
    lines_d = lines_q;
    score_d = score_q;
    if (state_q == IDLE && start) begin
      work_d = board_in;
      r_d    = '0;
      cnt_d  = '0;
    end else if (state_q == SCAN) begin
      if (row_full) begin
        work_d = shifted;
        cnt_d  = cnt_q + 4'd1;
      end else begin
        r_d = r_q + 4'd1;
      end
      if (scan_exit) begin
        board_d = work_q;
        lines_d = cnt_q;
        score_d = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
      end
    end
  end

  assign board_out = board_q;
  assign lines     = lines_q;
  assign score     = score_q;
  assign game_over = |board_q[31:28];

endmodule

// File: tb/tb_line_clear_unit.sv
// Directed and randomized checks of line_clear_unit against a row-list reference model.
// Narrow score width so saturation is reachable.
module tb_line_clear_unit;
  localparam int SW   = 8;
  localparam int SMAX = (1 << SW) - 1;

  logic          clka = 1'b0;
  logic          restart_n;
  logic          start;
  logic [31:0]   board_in;
  logic          busy;
  logic          done;
  logic [31:0]   board_out;
  logic [3:0]    lines;
  logic [SW-1:0] score;
  logic          game_over;

  int checks = 0;
  int errors = 0;
  int model_score = 0;

  always #5 clka = ~clka;

  line_clear_unit #(.SCORE_W(SW)) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .start     (start),
    .board_in  (board_in),
    .busy      (busy),
    .done      (done),
    .board_out (board_out),
    .lines     (lines),
    .score     (score),
    .game_over (game_over)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: keep every non-full row in bottom-to-top order, pad with empty rows on top.
  task automatic model(input logic [31:0] b, output logic [31:0] res, output int nl);
    logic [3:0] kept[$];
    logic [3:0] nib;
    for (int i = 0; i < 8; i++) begin
      nib = b[4*i +: 4];
      if (nib != 4'hF) kept.push_back(nib);
    end
    nl  = 8 - kept.size();
    res = '0;
    for (int i = 0; i < kept.size(); i++) res[4*i +: 4] = kept[i];
  endtask

  function automatic int points(input int l);
    if (l == 0) return 0;
    if (l == 1) return 1;
    if (l == 2) return 3;
    if (l == 3) return 5;
    return 8;
  endfunction

  task automatic apply_reset();
    restart_n = 1'b0;
    start     = 1'b0;
    @(posedge clka);
    @(posedge clka);
    #1;
    restart_n   = 1'b1;
    model_score = 0;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the DONE->IDLE edge.
  task automatic do_req(input string tag, input logic [31:0] b, input bit hold);
    logic [31:0] exp_b;
    int          exp_l;
    int          lat;
    model(b, exp_b, exp_l);
    model_score = model_score + points(exp_l);
    if (model_score > SMAX) model_score = SMAX;
    board_in = b;
    start    = 1'b1;
    @(posedge clka);
    #1;
    if (!hold) start = 1'b0;
    board_in = $urandom();
    check({tag, "/busy_scan"}, 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clka);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "/latency"},   32'(lat),       32'(8 + exp_l));
    check({tag, "/board_out"}, board_out,      exp_b);
    check({tag, "/lines"},     32'(lines),     32'(exp_l));
    check({tag, "/score"},     32'(score),     32'(model_score));
    check({tag, "/game_over"}, 32'(game_over), 32'(exp_b[31:28] != 4'h0));
    check({tag, "/busy_done"}, 32'(busy),      32'd1);
    @(posedge clka);
    #1;
    check({tag, "/done_1cyc"}, 32'(done),      32'd0);
    check({tag, "/idle"},      32'(busy),      32'd0);
    check({tag, "/hold"},      board_out,      exp_b);
  endtask

  initial begin
    logic [31:0] rb;
    int          done_seen;
    restart_n = 1'b0;
    start     = 1'b1;
    board_in  = 32'hFFFF_FFFF;
    @(posedge clka);
    @(posedge clka);
    #1;
    start     = 1'b0;
    restart_n = 1'b1;
    check("reset/busy",      32'(busy),      32'd0);
    check("reset/done",      32'(done),      32'd0);
    check("reset/board_out", board_out,      32'd0);
    check("reset/lines",     32'(lines),     32'd0);
    check("reset/score",     32'(score),     32'd0);
    check("reset/game_over", 32'(game_over), 32'd0);

    do_req("empty", 32'h0000_0000, 1'b0);
    do_req("two_lines", 32'h0000_F1F3, 1'b0);

    apply_reset();
    do_req("b2b_a", 32'hF0F0_F0F0, 1'b0);
    do_req("b2b_b", 32'h0000_000F, 1'b0);

    do_req("top_held_a", 32'h8000_0000, 1'b1);
    do_req("top_held_b", 32'h8000_0000, 1'b1);
    start = 1'b0;
    @(posedge clka);
    #1;
    check("held_release/busy", 32'(busy), 32'd0);

    // Abort a request with reset on its fourth scan edge.
    board_in = 32'hFFFF_FFFF;
    start    = 1'b1;
    @(posedge clka);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    restart_n = 1'b0;
    @(posedge clka);
    #1;
    restart_n   = 1'b1;
    model_score = 0;
    check("abort/busy",      32'(busy),      32'd0);
    check("abort/done",      32'(done),      32'd0);
    check("abort/board_out", board_out,      32'd0);
    check("abort/lines",     32'(lines),     32'd0);
    check("abort/score",     32'(score),     32'd0);
    check("abort/game_over", 32'(game_over), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clka);
      #1;
      if (done) done_seen++;
    end
    check("abort/no_done", 32'(done_seen), 32'd0);
    do_req("full_board", 32'hFFFF_FFFF, 1'b0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++)
        rb[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      do_req("random", rb, 1'($urandom_range(0, 1)));
      start = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clka);
        #1;
      end
    end

    apply_reset();
    for (int n = 0; n < 34; n++) do_req("saturate", 32'hFFFF_FFFF, 1'b0);
    check("saturate/final", 32'(score), 32'(SMAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
